// File: rtl/ps2_host_tx_pkg.sv
// Shared types and helpers for the PS/2 host-to-device transmitter.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_SHIFT,
    ST_ACK
  } state_t;

  localparam int BYTE_W      = 8;
  localparam int SHIFT_W     = BYTE_W + 2;
  localparam int FRAME_FALLS = 11;

  // Parity bit that makes the count of ones over data+parity odd.
  function automatic logic odd_parity(input logic [BYTE_W-1:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the PS/2 host transmitter.
interface ps2_host_tx_if;
  import ps2_host_tx_pkg::*;

  logic              i_valid;
  logic [BYTE_W-1:0] i_byte;
  logic              o_ready;
  logic              o_done;
  logic              o_err;

  modport master (output i_valid, output i_byte, input o_ready, input o_done, input o_err);
  modport slave  (input i_valid, input i_byte, output o_ready, output o_done, output o_err);

endinterface

// File: rtl/ps2_host_tx_clk_fall.sv
// Two-flop synchronizers for the PS/2 pins plus a falling-edge pulse on the clock pin.
module ps2_host_tx_clk_fall (
  input  logic clk,
  input  logic i_arst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_dat,
  output logic o_dat_s,
  output logic o_fall_en
);

  // [1] is the synchronized level, [2] its previous value; data shares the same latency.
  logic [2:0] clk_sync_q;
  logic [1:0] dat_sync_q;

  always_ff @(posedge clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], i_ps2_clk};
      dat_sync_q <= {dat_sync_q[0], i_ps2_dat};
    end
  end

  assign o_fall_en = clk_sync_q[2] & ~clk_sync_q[1];
  assign o_dat_s   = dat_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host transmitter: inhibits the bus, sends one command frame on device clock and checks the ACK.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int INHIBIT_CYCLES = 6_000,
  parameter int TIMEOUT_CYCLES = 750_000
) (
  input  logic         clk,
  input  logic         i_arst_n,
  input  logic         i_ps2_clk,
  input  logic         i_ps2_dat,
  ps2_host_tx_if.slave bus,
  output logic         o_ps2_clk_oe,
  output logic         o_ps2_dat_oe
);

  // The clock-low hold is never allowed below 100 us, whatever INHIBIT_CYCLES says.
  localparam int MIN_INHIBIT = (CLK_HZ + 9_999) / 10_000;
  localparam int INH_CYC     = (INHIBIT_CYCLES > MIN_INHIBIT) ? INHIBIT_CYCLES : MIN_INHIBIT;
  localparam int INH_W       = $clog2(INH_CYC + 1);
  localparam int TO_W        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BIT_W       = $clog2(FRAME_FALLS + 1);

  logic dat_s, fall_en;

  ps2_host_tx_clk_fall u_clk_fall (
    .clk       (clk),
    .i_arst_n  (i_arst_n),
    .i_ps2_clk (i_ps2_clk),
    .i_ps2_dat (i_ps2_dat),
    .o_dat_s   (dat_s),
    .o_fall_en (fall_en)
  );

  state_t             state_q, state_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0]   inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               clk_oe_q, clk_oe_d;
  logic               dat_oe_q, dat_oe_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               ready;

  // The done/err pulse cycle is still busy so a request there is not taken.
  assign ready = (state_q == ST_IDLE) && !done_q && !err_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        clk_oe_d  = 1'b0;
        dat_oe_d  = 1'b0;
        inh_cnt_d = '0;
        to_cnt_d  = '0;
        if (bus.i_valid && ready) begin
          shift_d  = {1'b1, odd_parity(bus.i_byte), bus.i_byte};
          clk_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (inh_cnt_q == INH_W'(INH_CYC - 1)) begin
          clk_oe_d  = 1'b0;
          dat_oe_d  = 1'b1;
          bit_cnt_d = '0;
          to_cnt_d  = '0;
          state_d   = ST_START;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      ST_START, ST_SHIFT, ST_ACK: begin
        if (fall_en) begin
          to_cnt_d = '0;
          if (state_q == ST_ACK) begin
            done_d   = ~dat_s;
            err_d    = dat_s;
            dat_oe_d = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            // Fall 10 puts the stop bit (a release) on the line; fall 11 carries the ACK.
            dat_oe_d  = ~shift_q[0];
            shift_d   = {1'b0, shift_q[SHIFT_W-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            state_d   = (bit_cnt_q == BIT_W'(FRAME_FALLS - 2)) ? ST_ACK : ST_SHIFT;
          end
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES)) begin
          err_d    = 1'b1;
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign bus.o_ready   = ready;
  assign bus.o_done    = done_q;
  assign bus.o_err     = err_q;
  assign o_ps2_clk_oe  = clk_oe_q;
  assign o_ps2_dat_oe  = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: PS/2 device model on open-drain pins, frame/outcome scoreboard.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int CLK_HZ = 100_000;
  localparam int INH    = 60;
  localparam int TO     = 400;
  localparam int HALF   = 20;
  localparam int M_OK = 0, M_NOACK = 1, M_STALL = 2, M_RST = 3;

  typedef struct {
    logic [10:0] frame;
    bit          ok;
    bit          chk;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic clk_oe, dat_oe;
  logic ps2_clk, ps2_dat;
  logic [10:0] dev_seen = '0;
  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  assign ps2_clk = ~(clk_oe | dev_clk_low);
  assign ps2_dat = ~(dat_oe | dev_dat_low);

  ps2_host_tx_if bus ();

  ps2_host_tx #(.CLK_HZ(CLK_HZ), .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .i_arst_n     (rst_n),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_dat    (ps2_dat),
    .bus          (bus),
    .o_ps2_clk_oe (clk_oe),
    .o_ps2_dat_oe (dat_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Frame as the device should see it: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    int ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic device(input int mode, input logic [7:0] b);
    int t = 0;
    dev_seen = '0;
    while (!(ps2_clk === 1'b1 && ps2_dat === 1'b0) && t < 4 * INH) begin
      @(negedge clk);
      t++;
    end
    if (t >= 4 * INH) begin
      check("start_seen", 32'd0, 32'd1);
      return;
    end
    dev_seen[0] = ps2_dat;
    repeat (HALF) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      if (mode == M_STALL && k == 5) return;
      if (k == 11 && mode != M_NOACK) dev_dat_low = 1'b1;
      dev_clk_low = 1'b1;
      if (mode == M_RST && k == 6) begin
        repeat (5) @(negedge clk);
        check("bit5_before_reset", 32'(dat_oe), 32'(!b[5]));
        #2 rst_n = 1'b0;
        #1;
        check("rst_clk_oe", 32'(clk_oe), 32'd0);
        check("rst_dat_oe", 32'(dat_oe), 32'd0);
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_done_err", 32'({bus.o_done, bus.o_err}), 32'd0);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k <= 10) dev_seen[k] = ps2_dat;
      repeat (HALF) @(negedge clk);
    end
    dev_dat_low = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int mode, input bit poke_busy, input bit poke_pulse);
    int t = 0;
    exp_t e;
    while (!bus.o_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!bus.o_ready) begin
      check("ready_wait", 32'd0, 32'd1);
      return;
    end
    if (mode != M_RST) begin
      e.frame = frame_of(b);
      e.ok    = (mode == M_OK);
      e.chk   = (mode != M_STALL);
      exp_q.push_back(e);
    end
    bus.i_valid = 1'b1;
    bus.i_byte  = b;
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_byte  = 8'($urandom);
    if (poke_busy) begin
      fork
        device(mode, b);
        begin
          repeat (100) @(negedge clk);
          bus.i_valid = 1'b1;
          repeat (10) @(negedge clk);
          bus.i_valid = 1'b0;
        end
      join
    end else if (poke_pulse) begin
      fork
        device(mode, b);
        begin
          int w = 0;
          while (!(bus.o_done || bus.o_err) && w < 4 * TO) begin
            @(negedge clk);
            w++;
          end
          bus.i_valid = 1'b1;
          @(negedge clk);
          bus.i_valid = 1'b0;
          repeat (5) @(negedge clk);
          check("pulse_valid_ignored", 32'(clk_oe), 32'd0);
          check("pulse_valid_ready", 32'(bus.o_ready), 32'd1);
        end
      join
    end else begin
      device(mode, b);
    end
    if (mode == M_STALL) begin
      t = 0;
      while (!bus.o_err && t < 3 * TO) begin
        @(negedge clk);
        t++;
      end
      check("timeout_window", 32'(t >= TO - 2 * HALF && t <= TO - 2 * HALF + 12), 32'd1);
    end
    t = 0;
    while (exp_q.size() != 0 && t < 3 * TO) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      check("result_wait", 32'd0, 32'd1);
      exp_q.delete();
    end
    repeat (5) @(negedge clk);
  endtask

  // Outcome monitor
  initial begin
    exp_t e;
    bit post = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        post = 1'b0;
      end else begin
        if (post) begin
          check("ready_after", 32'(bus.o_ready), 32'd1);
          check("oe_after", 32'({clk_oe, dat_oe}), 32'd0);
          post = 1'b0;
        end
        if (bus.o_done || bus.o_err) begin
          check("done_err_excl", 32'(bus.o_done & bus.o_err), 32'd0);
          check("ready_in_pulse", 32'(bus.o_ready), 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", 32'd0, 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("outcome_done", 32'(bus.o_done), 32'(e.ok));
            check("outcome_err", 32'(bus.o_err), 32'(!e.ok));
            if (e.chk) check("frame", 32'(dev_seen), 32'(e.frame));
          end
          post = 1'b1;
        end
      end
    end
  end

  // Clock-low hold length and oe overlap
  initial begin
    int inh_cnt = 0;
    logic clk_prev = 1'b0;
    logic dat_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        inh_cnt = 0;
        clk_prev = 1'b0;
        dat_prev = 1'b0;
      end else begin
        if (clk_oe && dat_oe) check("oe_overlap", 32'd1, 32'd0);
        if (dat_oe && !dat_prev && clk_prev) begin
          check("inhibit_len", 32'(inh_cnt), 32'(INH));
          check("clk_released_at_start", 32'(clk_oe), 32'd0);
        end
        inh_cnt  = clk_oe ? inh_cnt + 1 : 0;
        clk_prev = clk_oe;
        dat_prev = dat_oe;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_valid = 1'b0;
    bus.i_byte  = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(bus.o_ready), 32'd1);
    check("reset_oe", 32'({clk_oe, dat_oe}), 32'd0);
    check("reset_done_err", 32'({bus.o_done, bus.o_err}), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    send(8'hED, M_OK, 1'b1, 1'b0);
    send(8'h07, M_OK, 1'b0, 1'b0);
    send(8'hFF, M_OK, 1'b0, 1'b0);
    send(8'h00, M_OK, 1'b0, 1'b0);
    send(8'($urandom), M_OK, 1'b0, 1'b1);
    send(8'hA5, M_NOACK, 1'b0, 1'b0);
    send(8'($urandom), M_STALL, 1'b0, 1'b0);
    send(8'hF4, M_OK, 1'b0, 1'b0);
    send(8'h1C, M_RST, 1'b0, 1'b0);
    repeat (50) @(negedge clk);
    check("post_reset_idle", 32'({clk_oe, dat_oe}), 32'd0);
    for (int i = 0; i < 5; i++) send(8'($urandom), M_OK, 1'b0, 1'b0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
